// File: rtl/level_bar_encoder.sv
// level_bar_encoder: per-frame peak magnitude to LED bar pattern with decaying bar and held peak dot.
// Define LEVEL_BAR_PEAK_HOLD_EN to include the peak dot; otherwise the pattern is the bar only.
module level_bar_encoder #(
    parameter int width            = 32,
    parameter int sample_width     = 16,
    parameter int frame_samples    = 1024,
    parameter int decay_frames     = 2,
    parameter int peak_hold_frames = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_valid,
    input  logic [sample_width-1:0] i_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [width-1:0]        o_data
);
    localparam int MW = sample_width - 1;
    localparam int LW = $clog2(width + 1);
    localparam int CW = $clog2(frame_samples);
    localparam int DW = $clog2(decay_frames + 1);
    localparam int PW = sample_width + $clog2(width) + 1;
    localparam logic [CW-1:0] LAST = CW'(frame_samples - 1);
    localparam logic [DW-1:0] DLAST = DW'(decay_frames - 1);
    localparam logic [width-1:0] ALL = '1;
    typedef enum logic [1:0] {IDLE, UPDATE, PRESENT} state_t;
    state_t state, state_d;
    logic [sample_width-1:0] neg;
    logic [MW-1:0] m, acc, snap, fmax;
    logic [CW-1:0] scount;
    logic pend, fe, take;
    logic [PW-1:0] prod;
    logic [LW-1:0] lvl, lvl_q, bar, bar_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [width-1:0] dot, pat;
`ifdef LEVEL_BAR_PEAK_HOLD_EN
    localparam int HW = $clog2(peak_hold_frames + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(peak_hold_frames);
    localparam logic [width-1:0] ONE = width'(1);
    logic [LW-1:0] pk, pk_n;
    logic [HW-1:0] hold, hold_n;
`endif
    assign o_valid = state == PRESENT;
    always_comb begin
        neg = ~i_data + 1'b1;
        m = !i_data[MW] ? i_data[MW-1:0] : (neg[MW] ? '1 : neg[MW-1:0]);
        fe = i_valid && scount == LAST;
        fmax = m > acc ? m : acc;
        take = state == IDLE && pend;
        prod = (PW'(snap) + PW'(1)) * PW'(width);
        lvl = LW'(prod >> MW);
        bar_n = lvl_q >= bar ? lvl_q : (dcnt == DLAST ? bar - 1'b1 : bar);
        dcnt_n = (lvl_q >= bar || dcnt == DLAST) ? '0 : dcnt + 1'b1;
`ifdef LEVEL_BAR_PEAK_HOLD_EN
        // the peak only starts falling once hold has expired, and never below the new bar
        pk_n = lvl_q >= pk ? lvl_q : ((hold == '0 && pk > bar_n) ? pk - 1'b1 : pk);
        hold_n = lvl_q >= pk ? HOLD_INIT : (hold != '0 ? hold - 1'b1 : hold);
        dot = pk_n != '0 ? ONE << (pk_n - 1'b1) : '0;
`else
        dot = '0;
`endif
        pat = (bar_n == '0 ? '0 : ALL >> (LW'(width) - bar_n)) | dot;
        state_d = take ? UPDATE : state == UPDATE ? PRESENT : (state == PRESENT && o_ready) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end
    // lvl is captured as UPDATE starts so a frame ending on that edge can refill snap without being lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scount <= '0;
            acc    <= '0;
            snap   <= '0;
            pend   <= 1'b0;
            lvl_q  <= '0;
            bar    <= '0;
            dcnt   <= '0;
            o_data <= '0;
`ifdef LEVEL_BAR_PEAK_HOLD_EN
            pk     <= '0;
            hold   <= '0;
`endif
        end else begin
            if (i_valid) begin
                scount <= fe ? '0 : scount + 1'b1;
                acc    <= fe ? '0 : fmax;
            end
            if (fe) begin
                snap <= (pend && !take) ? (fmax > snap ? fmax : snap) : fmax;
                pend <= 1'b1;
            end else if (take) begin
                pend <= 1'b0;
            end
            if (take) lvl_q <= lvl;
            if (state == UPDATE) begin
                bar    <= bar_n;
                dcnt   <= dcnt_n;
                o_data <= pat;
`ifdef LEVEL_BAR_PEAK_HOLD_EN
                pk     <= pk_n;
                hold   <= hold_n;
`endif
            end
        end
    end
endmodule

// File: tb/tb_level_bar_encoder.sv
// tb_level_bar_encoder: directed and randomized checks of level_bar_encoder against a frame-level model.
module tb_level_bar_encoder;
    localparam int W = 32, SW = 16, FS = 4, DF = 2, PH = 3;
    logic clk = 1'b0;
    logic reset, i_valid, o_valid, o_ready;
    logic [SW-1:0] i_data;
    logic [W-1:0] o_data;
    int tests = 0, fails = 0;
    int m_bar, m_dc, m_pk, m_hold;

    always #5 clk = ~clk;

    level_bar_encoder #(.width(W), .sample_width(SW), .frame_samples(FS),
                        .decay_frames(DF), .peak_hold_frames(PH)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data));

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int mag(input logic [SW-1:0] s);
        int v;
        v = int'($signed(s));
        v = v < 0 ? -v : v;
        return v > 32767 ? 32767 : v;
    endfunction

    // One presented pattern per call; the frame maximum is turned into a level and applied to the bar/peak.
    task automatic model_frame(input int fm, output logic [W-1:0] e);
        int lvl;
        lvl = ((fm + 1) * W) >> (SW - 1);
        if (lvl >= m_bar) begin
            m_bar = lvl;
            m_dc = 0;
        end else begin
            m_dc++;
            if (m_dc == DF) begin
                m_bar--;
                m_dc = 0;
            end
        end
        e = '0;
        for (int i = 0; i < m_bar; i++) e[i] = 1'b1;
`ifdef LEVEL_BAR_PEAK_HOLD_EN
        if (lvl >= m_pk) begin
            m_pk = lvl;
            m_hold = PH;
        end else if (m_hold > 0) m_hold--;
        else if (m_pk > m_bar) m_pk--;
        if (m_pk > 0) e[m_pk-1] = 1'b1;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_valid = 1'b0;
        i_data = '0;
        o_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_bar = 0; m_dc = 0; m_pk = 0; m_hold = 0;
    endtask

    task automatic send(input logic [SW-1:0] v);
        i_valid = 1'b1;
        i_data = v;
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [SW-1:0] a, b, c, d, output int fm);
        logic [SW-1:0] s [4];
        s = '{a, b, c, d};
        fm = 0;
        for (int k = 0; k < 4; k++) begin
            send(s[k]);
            if (mag(s[k]) > fm) fm = mag(s[k]);
        end
    endtask

    task automatic wait_pattern(output logic [W-1:0] d, output bit ok);
        ok = 1'b0;
        d = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (o_valid) begin
                d = o_data;
                ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_valid = 1'b0;
        i_data = '0;
        o_ready = 1'b1;
        #2;
        tests++;
        if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        tests++;
        if (o_data !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", o_data); end
        do_reset();
        repeat (3) @(negedge clk);
        tests++;
        if (o_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b expected 0", o_valid); end
    endtask

    task automatic test_full_scale();
        int fm;
        logic [W-1:0] e;
        do_reset();
        send_frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, fm);
        model_frame(fm, e);
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b0) begin fails++; $display("FAIL latency_n0: got %b expected 0", o_valid); end
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b0) begin fails++; $display("FAIL latency_n1: got %b expected 0", o_valid); end
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b1) begin fails++; $display("FAIL latency_n2: got %b expected 1", o_valid); end
        tests++;
        if (o_data !== 32'hFFFF_FFFF) begin fails++; $display("FAIL full_scale: got %h expected ffffffff", o_data); end
        tests++;
        if (o_data !== e) begin fails++; $display("FAIL full_scale_model: got %h expected %h", o_data, e); end
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b0) begin fails++; $display("FAIL valid_drop: got %b expected 0", o_valid); end
    endtask

    task automatic test_saturation();
        int fm;
        bit ok;
        logic [W-1:0] d, e;
        do_reset();
        send_frame(16'h8000, 16'h0, 16'h0, 16'h0, fm);
        model_frame(fm, e);
        wait_pattern(d, ok);
        tests++;
        if (!ok || d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL saturation: got %h ok=%b expected ffffffff", d, ok); end
        for (int f = 0; f < 6; f++) begin
            send_frame(16'h4000, 16'h0, 16'h0, 16'h0, fm);
            model_frame(fm, e);
            wait_pattern(d, ok);
            tests++;
            if (!ok || d !== e) begin fails++; $display("FAIL mid_scale frame %0d: got %h ok=%b expected %h", f, d, ok, e); end
        end
    endtask

    task automatic test_decay();
        int fm;
        bit ok;
        logic [W-1:0] d, e;
        do_reset();
        send_frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, fm);
        model_frame(fm, e);
        wait_pattern(d, ok);
        for (int f = 0; f < 12; f++) begin
            send_frame(16'h0, 16'h0, 16'h0, 16'h0, fm);
            model_frame(fm, e);
            wait_pattern(d, ok);
            tests++;
            if (!ok || d !== e) begin fails++; $display("FAIL decay frame %0d: got %h ok=%b expected %h", f, d, ok, e); end
`ifndef LEVEL_BAR_PEAK_HOLD_EN
            tests++;
            if ((d & (d + 1'b1)) !== '0) begin fails++; $display("FAIL contiguous frame %0d: got %h", f, d); end
`endif
        end
    endtask

    task automatic test_backpressure();
        int fm, merged;
        bit ok;
        logic [W-1:0] d, e;
        do_reset();
        o_ready = 1'b0;
        send_frame(16'd100, 16'h0, 16'h0, 16'h0, fm);
        model_frame(fm, e);
        send_frame(16'h0, 16'h4000, 16'h0, 16'h0, merged);
        send_frame(16'h0, 16'h0, 16'd200, 16'h0, fm);
        if (fm > merged) merged = fm;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (o_valid !== 1'b1 || o_data !== e) begin fails++; $display("FAIL hold_stable %0d: got v=%b d=%h expected v=1 d=%h", i, o_valid, o_data, e); end
        end
        @(posedge clk);
        #1 o_ready = 1'b1;
        @(posedge clk);
        #1;
        model_frame(merged, e);
        wait_pattern(d, ok);
        tests++;
        if (!ok || d !== e) begin fails++; $display("FAIL merged_model: got %h ok=%b expected %h", d, ok, e); end
        tests++;
        if (d !== 32'h0000_FFFF) begin fails++; $display("FAIL merged_const: got %h expected 0000ffff", d); end
        repeat (8) @(negedge clk);
        tests++;
        if (o_valid !== 1'b0) begin fails++; $display("FAIL no_extra_pattern: got %b expected 0", o_valid); end
    endtask

    task automatic test_reset_mid_present();
        int fm;
        bit ok;
        logic [W-1:0] d, e;
        do_reset();
        o_ready = 1'b0;
        send_frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, fm);
        send_frame(16'h7000, 16'h0, 16'h0, 16'h0, fm);
        wait_pattern(d, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL present_before_reset: got no pattern expected one"); end
        #1 reset = 1'b1;
        #1;
        tests++;
        if (o_valid !== 1'b0 || o_data !== '0) begin fails++; $display("FAIL async_reset: got v=%b d=%h expected 0/0", o_valid, o_data); end
        @(negedge clk);
        reset = 1'b0;
        o_ready = 1'b1;
        m_bar = 0; m_dc = 0; m_pk = 0; m_hold = 0;
        @(posedge clk);
        #1;
        send_frame(16'h0, 16'h0, 16'h0, 16'h0, fm);
        model_frame(fm, e);
        wait_pattern(d, ok);
        tests++;
        if (!ok || d !== e || d !== '0) begin fails++; $display("FAIL after_reset: got %h ok=%b expected %h", d, ok, e); end
        repeat (8) @(negedge clk);
        tests++;
        if (o_valid !== 1'b0) begin fails++; $display("FAIL snapshot_discarded: got %b expected 0", o_valid); end
    endtask

    task automatic test_random();
        int fm, amp, v;
        bit ok;
        logic [SW-1:0] s;
        logic [W-1:0] d, e;
        do_reset();
        for (int f = 0; f < 30; f++) begin
            amp = $urandom_range(0, 32767);
            fm = 0;
            for (int k = 0; k < FS; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                v = $urandom_range(0, amp);
                s = $urandom_range(0, 1) ? SW'(-v) : SW'(v);
                if ($urandom_range(0, 20) == 0) s = 16'h8000;
                send(s);
                if (mag(s) > fm) fm = mag(s);
            end
            model_frame(fm, e);
            wait_pattern(d, ok);
            tests++;
            if (!ok || d !== e) begin fails++; $display("FAIL random frame %0d max %0d: got %h ok=%b expected %h", f, fm, d, ok, e); end
        end
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_saturation();
        test_decay();
        test_backpressure();
        test_reset_mid_present();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
